// File: rtl/booth_mult_r4.sv
// Radix-4 Booth multiplier for 32x32 signed/unsigned products (mult/multu).
// One Booth digit per cycle over a 34-bit multiplier: 17 steps, then the product is published.
module booth_mult_r4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [34:0] r_mcand;
    logic [33:0] r_mplier;
    logic        r_bPrev;
    logic [36:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_fin;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [36:0] w_m1;
    logic [36:0] w_m2;
    logic [36:0] w_addend;
    logic [36:0] w_sum;
    logic [36:0] w_accShift;
    logic [33:0] w_mplierShift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CALC;
            CALC:    if (r_fin) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Booth digit from {b[i+1], b[i], b[i-1]} selects 0, +-M or +-2M.
    always_comb begin
        w_m1 = {{2{r_mcand[34]}}, r_mcand};
        w_m2 = {w_m1[35:0], 1'b0};
        case ({r_mplier[1:0], r_bPrev})
            3'b001, 3'b010: w_addend = w_m1;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = -w_m2;
            3'b101, 3'b110: w_addend = -w_m1;
            default:        w_addend = '0;
        endcase
        w_sum         = r_acc + w_addend;
        w_accShift    = {{2{w_sum[36]}}, w_sum[36:2]};
        w_mplierShift = {w_sum[1:0], r_mplier[33:2]};
    end

    // r_fin marks that the 17th step is complete; the following edge publishes the product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_bPrev  <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_fin    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= signed_op ? {{3{a_in[31]}}, a_in} : {3'b000, a_in};
                        r_mplier <= signed_op ? {{2{b_in[31]}}, b_in} : {2'b00, b_in};
                        r_bPrev  <= 1'b0;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_fin    <= 1'b0;
                    end
                end
                CALC: begin
                    if (!r_fin) begin
                        r_acc    <= w_accShift;
                        r_mplier <= w_mplierShift;
                        r_bPrev  <= r_mplier[1];
                        if (r_cnt == 5'd16) begin
                            r_fin <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end else begin
                        r_hi <= {r_acc[29:0], r_mplier[33:32]};
                        r_lo <= r_mplier[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;
    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);

endmodule
